// File: rtl/regfile_pkg.sv
// Shared widths, sizes and types for the 32 x 64-bit CPU register file.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 64;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

endpackage

// File: rtl/regfile_decoder5_32.sv
// Write-port address decoder: 5-bit index plus enable to a one-hot enable vector.
module decoder5_32
    import regfile_pkg::*;
(
    input  logic                en,
    input  reg_addr_t           idx,
    output logic [NUM_REGS-1:0] onehot
);

    // Gating on en first keeps an unknown idx from touching any enable while idle.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_mux32_1.sv
// Single-bit 32:1 read selector: four 8:1 cells on sel[2:0] feeding a 4:1 cell on sel[4:3].
module mux32_1 (
    input  logic [31:0] d,
    input  logic [4:0]  sel,
    output logic        y
);

    logic [3:0] m8;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            m8[i] = d[{i[1:0], sel[2:0]}];
        end
    end

    assign y = m8[sel[4:3]];

endmodule

// File: rtl/regfile.sv
// 32 x 64-bit register file, two combinational read ports, one synchronous write port.
// X31 has no storage and always reads as zero.
module regfile
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      RegWrite,
    input  reg_addr_t WriteRegister,
    input  reg_data_t WriteData,
    input  reg_addr_t ReadRegister1,
    input  reg_addr_t ReadRegister2,
    output reg_data_t ReadData1,
    output reg_data_t ReadData2
);

    localparam int NUM_STORED = int'(ZERO_REG);

    logic [NUM_STORED-1:0] we;
    logic                  we_unused;
    reg_data_t             regs_d [NUM_STORED];
    reg_data_t             regs_q [NUM_STORED];
    logic [NUM_REGS-1:0]   col    [DATA_W];

    decoder5_32 u_dec (
        .en     (RegWrite),
        .idx    (WriteRegister),
        .onehot ({we_unused, we})
    );

    always_comb begin
        for (int r = 0; r < NUM_STORED; r++) begin
            regs_d[r] = we[r] ? WriteData : regs_q[r];
        end
    end

    // Reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_STORED; r++) begin
            if (reset) begin
                regs_q[r] <= '0;
            end else begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // Bit-sliced view of the array so each read mux sees one bit of every register.
    always_comb begin
        for (int b = 0; b < DATA_W; b++) begin
            col[b] = '0;
            for (int r = 0; r < NUM_STORED; r++) begin
                col[b][r] = regs_q[r][b];
            end
        end
    end

    for (genvar b = 0; b < DATA_W; b++) begin : g_rd
        mux32_1 u_mux1 (
            .d   (col[b]),
            .sel (ReadRegister1),
            .y   (ReadData1[b])
        );
        mux32_1 u_mux2 (
            .d   (col[b]),
            .sel (ReadRegister2),
            .y   (ReadData2[b])
        );
    end

endmodule

// File: tb/tb_regfile.sv
// Directed and random checks of regfile against an array-based reference model.
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int errors = 0;
    int checks = 0;

    logic [63:0] model [32];

    always #5 clk = ~clk;

    regfile dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    function automatic logic [63:0] model_rd(input logic [4:0] idx);
        return (idx == 5'd31) ? 64'd0 : model[idx];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reads(input string tag);
        check({tag, "_rd1"}, ReadData1, model_rd(ReadRegister1));
        check({tag, "_rd2"}, ReadData2, model_rd(ReadRegister2));
    endtask

    // One clock: drive at negedge, check reads before and after the rising edge.
    task automatic cycle(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [4:0] ra1, input logic [4:0] ra2,
                         input string tag);
        @(negedge clk);
        reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
        ReadRegister1 = ra1; ReadRegister2 = ra2;
        #1;
        check_reads({tag, "_pre"});
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) model[r] = 64'd0;
        end else if (we && wa != 5'd31) begin
            model[wa] = wd;
        end
        #1;
        check_reads({tag, "_post"});
    endtask

    task automatic sweep(input string tag);
        @(negedge clk);
        reset = 1'b0; RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            check_reads(tag);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) model[r] = 64'd0;
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        @(posedge clk);
        #1;
        sweep("powerup");

        cycle(1'b0, 1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 5'd5, 5'd6, "wr_x5");
        check("x5_value", ReadData1, 64'hDEADBEEF_CAFEF00D);
        sweep("after_x5");

        cycle(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, "wr_x31");
        check("x31_rd1_zero", ReadData1, 64'd0);
        check("x31_rd2_zero", ReadData2, 64'd0);

        cycle(1'b0, 1'b0, 5'd5, 64'd0, 5'd5, 5'd5, "we0_x5");
        check("x5_held", ReadData1, 64'hDEADBEEF_CAFEF00D);
        cycle(1'b0, 1'b0, 5'bx, 64'h1234, 5'd5, 5'd0, "we0_xaddr");

        cycle(1'b0, 1'b1, 5'd7, 64'h1, 5'd0, 5'd7, "x7_init");
        @(negedge clk);
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h2;
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd7;
        #1;
        check("x7_before_edge", ReadData1, 64'h1);
        check("x7_before_edge_p2", ReadData2, 64'h1);
        @(posedge clk);
        model[7] = 64'h2;
        #1;
        check("x7_after_edge", ReadData1, 64'h2);
        check("x7_after_edge_p2", ReadData2, 64'h2);

        for (int i = 0; i < 31; i++) begin
            cycle(1'b0, 1'b1, 5'(i), 64'(i) * 64'h0101_0101_0101_0101, 5'(i), 5'(30 - i), "fill");
        end
        sweep("filled");
        cycle(1'b1, 1'b1, 5'd3, 64'hAA, 5'd3, 5'd4, "rst_vs_wr");
        check("x3_cleared", ReadData1, 64'd0);
        sweep("after_reset");

        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 39) == 0), 1'($urandom), 5'($urandom), {$urandom, $urandom},
                  5'($urandom), 5'($urandom), "rand");
        end
        sweep("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32-entry x 64-bit general-purpose register file for the single-cycle CPU datapath.
- Sits directly upstream of the ALU and its result-select mux tree; its two read ports supply the ALU operands.
- The ALU/memory result comes back into its write port at the clock edge.
- X31 is hardwired to zero (XZR).

Parameters:
- NUM_REGS, 32, number of architectural registers; fixed at 32 because the address width is 5.
- WIDTH, 64, data width of each register in bits.
- ZERO_REG, 31, index of the hardwired-zero register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all registers at the rising edge.
- RegWrite  input  1  write enable for the write port.
- WriteRegister  input  5  destination register index.
- WriteData  input  WIDTH  data to write.
- ReadRegister1  input  5  read port 1 register index.
- ReadRegister2  input  5  read port 2 register index.
- ReadData1  output  WIDTH  contents of ReadRegister1.
- ReadData2  output  WIDTH  contents of ReadRegister2.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Storage: 31 writable WIDTH-bit registers, X0..X30, each a bank of D flip-flops. X31 has no storage and is a constant 0.
- Reset: at a rising edge with reset=1, X0..X30 become 0.
  - Reset has priority over RegWrite in the same cycle; the write is dropped.
  - Before that edge, outputs still show the old contents.
  - From the cycle after the reset edge, ReadData1 = ReadData2 = 0 for every index.
- Write: at a rising edge with reset=0 and RegWrite=1, register[WriteRegister] <= WriteData.
  - Exactly one register is written.
  - All other registers hold their value.
- Writes to ZERO_REG: silently ignored; reads of index 31 always return 0.
- RegWrite=0: no register changes, regardless of WriteRegister and WriteData.
- Reads: purely combinational, zero-cycle latency; ReadDataN = register[ReadRegisterN].
  - Read-during-write to the same index returns the old value until the edge and the new value after it. There is no write-through bypass.
- Both read ports may address the same register, including the one being written; each port behaves independently.
- X/unknown on WriteRegister while RegWrite=0 must not corrupt state.
- No handshake: the register file is always ready; one write per cycle, two reads per cycle.

Decomposition:
- Package regfile_pkg holds:
  - REG_ADDR_W = 5
  - DATA_W = 64
  - NUM_REGS = 32
  - ZERO_REG = 5'd31
  - typedef reg_addr_t = logic [4:0]
  - typedef reg_data_t = logic [63:0]
- Sub-module decoder5_32: 5-bit index plus enable to a 32-bit one-hot write-enable vector. Bit 31 of the vector is left unconnected.
- Sub-module mux32_1: a 32:1 single-bit read selector.
  - Built as four 8:1 mux cells feeding a 4:1 mux cell.
  - Instantiated WIDTH times per read port; index bit [4:3] selects among the 8:1 outputs, bits [2:0] drive the 8:1 selects.
- Each writable register is a per-bit D flip-flop with a load enable: hold when the enable is 0, load WriteData when it is 1, clear on reset.

Test Plan:
- Power-up: reset=1 for 1 cycle, then read indices 0..31 on both ports -> all 0.
- Write X5 = 64'hDEADBEEF_CAFEF00D with RegWrite=1 -> from the next cycle, ReadData1 (index 5) = 64'hDEADBEEF_CAFEF00D; all other indices still 0.
- Write X31 = 64'hFFFF_FFFF_FFFF_FFFF with RegWrite=1 -> read X31 = 0 on both ports.
- Set RegWrite=0 with WriteRegister=5, WriteData=0 -> X5 unchanged (64'hDEADBEEF_CAFEF00D).
- Read and write X7 in the same cycle (old value 64'h1, new value 64'h2) -> ReadData1 = 64'h1 before the edge and 64'h2 after it.
- Fill X0..X30 with index*64'h0101_0101_0101_0101, then assert reset=1 and RegWrite=1 (X3 = 64'hAA) together -> after the edge every read returns 0, including X3.
